id_ex_control: RTL and testbench

//   ID-stage main control for the 5-stage pipeline. Decodes opcode into the datapath

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/id_ex_control_main_decoder.sv | 53 +++++
 rtl/id_ex_control.sv | 110 +++++++++++
 tb/tb_id_ex_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the pipeline control slice.
package pipe_ctrl_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALU_OP_W = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ORI   = 2'b11;

    // Datapath control bundle carried from ID into EX.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_control_main_decoder.sv
// Main opcode decoder: opcode -> control bundle plus source-register usage.
module main_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                uses_rs,
    output logic                uses_rt,
    output logic                known
);

    // Decode opcode; unknown opcodes produce an all-zero bundle.
    always_comb begin
        ctrl    = CTRL_NOP;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        known   = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALU_OP_RTYPE;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_OP_ADD;
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OP_ADD;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OP_ORI;
                uses_rs        = 1'b1;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_control.sv
// ID-stage control: decode, load-use hazard detection, bubble insertion and ID/EX register.
module id_ex_control
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  id_instr,
    input  logic                id_valid,
    input  logic                flush,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_alu_src,
    output logic                ex_reg_dst,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [FUNCT_W-1:0]  ex_funct,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_rd,
    output logic                illegal_op
);

    ctrl_t              dec_ctrl;
    ctrl_t              ex_ctrl;
    logic               uses_rs;
    logic               uses_rt;
    logic               known;
    logic               stall;
    logic               bubble;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic [REG_W-1:0]   id_rd;
    logic [FUNCT_W-1:0] id_funct;
    logic               unused_shamt;

    main_decoder u_main_decoder (
        .opcode  (id_instr[31:26]),
        .ctrl    (dec_ctrl),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .known   (known)
    );

    assign id_rs        = REG_W'(id_instr[25:21]);
    assign id_rt        = REG_W'(id_instr[20:16]);
    assign id_rd        = REG_W'(id_instr[15:11]);
    assign id_funct     = FUNCT_W'(id_instr[5:0]);
    assign unused_shamt = ^id_instr[10:6];

    // Load-use hazard against the load sitting in EX; a redirect flush suppresses it.
    always_comb begin
        stall = 1'b0;
        if (!flush && id_valid && ex_valid && ex_ctrl.mem_read && (ex_rt != '0)) begin
            stall = (uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt));
        end
    end

    assign bubble     = flush || stall || !id_valid;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    // ID/EX register: bubble zeroes valid and controls, fields always follow ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_funct <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else begin
            ex_funct <= id_funct;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            if (bubble) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_NOP;
            end else begin
                ex_valid <= 1'b1;
                ex_ctrl  <= dec_ctrl;
            end
        end
    end

    // Sticky flag for an unknown opcode that actually issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (!bubble && !known) begin
            illegal_op <= 1'b1;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed table-driven bench for id_ex_control.
module tb_id_ex_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush;
    logic        pc_write;
    logic        ifid_write;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_alu_src;
    logic        ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        illegal_op;

    int n_cmp;
    int n_bad;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}
    localparam logic [7:0] C_R   = 8'b1000_0110;
    localparam logic [7:0] C_LW  = 8'b1101_1000;
    localparam logic [7:0] C_SW  = 8'b0010_1000;
    localparam logic [7:0] C_ORI = 8'b1000_1011;
    localparam logic [7:0] C_NOP = 8'b0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic        pcw;
        logic        exv;
        logic [7:0]  ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    id_ex_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .flush         (flush),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_op     (ex_alu_op),
        .ex_funct      (ex_funct),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic valid, input logic fl,
                                 input logic pcw, input logic exv, input logic [7:0] ctrl,
                                 input logic ill);
        vec_t v;
        v.instr = instr; v.valid = valid; v.flush = fl;
        v.pcw = pcw; v.exv = exv; v.ctrl = ctrl; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_alu_src, ex_reg_dst, ex_alu_op};
    endfunction

    task automatic check_regs(input string tag, input logic [31:0] instr, input logic exv,
                              input logic [7:0] ctrl, input logic ill);
        check({tag, " ex_valid"}, 32'(ex_valid), 32'(exv));
        check({tag, " ctrl"}, 32'(ctrl_now()), 32'(ctrl));
        check({tag, " ex_funct"}, 32'(ex_funct), 32'(instr[5:0]));
        check({tag, " ex_rs"}, 32'(ex_rs), 32'(instr[25:21]));
        check({tag, " ex_rt"}, 32'(ex_rt), 32'(instr[20:16]));
        check({tag, " ex_rd"}, 32'(ex_rd), 32'(instr[15:11]));
        check({tag, " illegal_op"}, 32'(illegal_op), 32'(ill));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc_write"}, 32'(pc_write), 32'd1);
        check({tag, " ifid_write"}, 32'(ifid_write), 32'd1);
        check_regs(tag, 32'd0, 1'b0, C_NOP, 1'b0);
    endtask

    logic [31:0] add_r5;
    logic [31:0] lw_r5;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n    = 1'b0;
        id_instr = 32'd0;
        id_valid = 1'b0;
        flush    = 1'b0;

        lw_r5  = mk_i(6'b100011, 5'd1, 5'd5, 16'h0010);
        add_r5 = mk_r(5'd5, 5'd1, 5'd6, 6'b100000);

        // Pipeline sequence; pcw is sampled before the edge, the rest after it.
        vecs.push_back(mkv(mk_r(5'd1, 5'd2, 5'd3, 6'b000010), 1, 0, 1, 1, C_R, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(add_r5, 1, 0, 0, 0, C_NOP, 0));
        vecs.push_back(mkv(add_r5, 1, 0, 1, 1, C_R, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_i(6'b001101, 5'd5, 5'd7, 16'h00ff), 1, 0, 0, 0, C_NOP, 0));
        vecs.push_back(mkv(mk_i(6'b001101, 5'd5, 5'd7, 16'h00ff), 1, 0, 1, 1, C_ORI, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_i(6'b101011, 5'd2, 5'd5, 16'h0004), 1, 0, 0, 0, C_NOP, 0));
        vecs.push_back(mkv(mk_i(6'b101011, 5'd2, 5'd5, 16'h0004), 1, 0, 1, 1, C_SW, 0));
        vecs.push_back(mkv(mk_i(6'b100011, 5'd1, 5'd0, 16'h0000), 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_r(5'd0, 5'd0, 5'd4, 6'b100000), 1, 0, 1, 1, C_R, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(add_r5, 1, 1, 1, 0, C_NOP, 0));
        vecs.push_back(mkv(add_r5, 0, 0, 1, 0, C_NOP, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_i(6'b001101, 5'd1, 5'd5, 16'h1234), 1, 0, 1, 1, C_ORI, 0));
        vecs.push_back(mkv(lw_r5, 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_i(6'b100011, 5'd2, 5'd5, 16'h0008), 1, 0, 1, 1, C_LW, 0));
        vecs.push_back(mkv(mk_i(6'b111111, 5'd3, 5'd4, 16'hffff), 1, 1, 1, 0, C_NOP, 0));
        vecs.push_back(mkv(mk_i(6'b111111, 5'd3, 5'd4, 16'hffff), 0, 0, 1, 0, C_NOP, 0));
        vecs.push_back(mkv(mk_i(6'b111111, 5'd3, 5'd4, 16'hffff), 1, 0, 1, 1, C_NOP, 1));
        vecs.push_back(mkv(mk_r(5'd1, 5'd2, 5'd3, 6'b000010), 1, 0, 1, 1, C_R, 1));

        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            id_instr = vecs[i].instr;
            id_valid = vecs[i].valid;
            flush    = vecs[i].flush;
            #1;
            check({tag, " pc_write"}, 32'(pc_write), 32'(vecs[i].pcw));
            check({tag, " ifid_write"}, 32'(ifid_write), 32'(vecs[i].pcw));
            @(posedge clk);
            #1;
            check_regs(tag, vecs[i].instr, vecs[i].exv, vecs[i].ctrl, vecs[i].ill);
        end

        // Reset asserted in the middle of a load-use stall.
        @(negedge clk);
        id_instr = lw_r5;
        id_valid = 1'b1;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        check("mid lw ex_mem_read", 32'(ex_mem_read), 32'd1);
        @(negedge clk);
        id_instr = add_r5;
        #1;
        check("mid stall pc_write", 32'(pc_write), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset pc_write", 32'(pc_write), 32'd1);
        @(posedge clk);
        #1;
        check_regs("post reset add", add_r5, 1'b1, C_R, 1'b0);

        id_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the sequence above stalls on a clock wait.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
